// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multi-cycle MIPS sequencing controller.
//   Opcode constants, the 4-bit state encoding, datapath mux select codes,
//   ALU operation codes and trap cause codes.
package mc_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned WAIT_W   = 8;

    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_IMM_EX   = 4'd6,
        S_IMM_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    // ALU B operand select
    localparam logic [1:0] ASB_B       = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

    // next-PC select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: datapath-side bus of the sequencing controller.
//   master: the controller (takes opcode/zero/mem_ready, drives selects,
//           strobes, debug state, trap status and retired count).
//   slave : the datapath / memory side (the reverse directions).
interface mc_control_if #(
    parameter int unsigned CNT_W = 32
) ();
    import mc_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                pc_en;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_write;
    logic                mem_to_reg;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [2:0]          alu_ctrl;
    logic [1:0]          pc_source;
    logic [STATE_W-1:0]  state;
    logic                trap;
    logic [1:0]          trap_cause;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_source,
               state, trap, trap_cause, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_source,
               state, trap, trap_cause, retired
    );

endinterface

// File: rtl/mc_waitcnt.sv
// mc_waitcnt: memory-phase wait counter.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : clear the count (state change)
//   i_en     : count one stalled cycle
//   o_term_c : this stalled cycle is the WAIT_MAX-th one (combinational)
module mc_waitcnt
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term_c
);

    logic [WAIT_W-1:0] r_count;

    // Flag the stall that would bring the count up to WAIT_MAX
    assign o_term_c = i_en && (r_count == WAIT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle sequencing controller for the MIPS core.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mc_control_if.master -- opcode/zero/mem_ready in; mux selects,
//              memory/register strobes, pc_en, debug state, sticky trap with
//              cause, and retired-instruction count out.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    mc_control_if.master    bus
);

    state_t           r_state;
    state_t           w_next;
    logic             r_trap;
    logic [1:0]       r_trap_cause;
    logic [CNT_W-1:0] r_retired;

    logic       w_cause;
    logic [1:0] w_cause_code;
    logic       w_retire;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_to_reg;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_alu_ctrl;
    logic [1:0] w_pc_source;
    logic       w_wait_en;
    logic       w_wait_clr;
    logic       w_wait_term;

    // Stall counting only in memory phases; any state change restarts the count
    assign w_wait_en  = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                         (r_state == S_MEM_WR)) && !bus.mem_ready;
    assign w_wait_clr = (w_next != r_state);

    mc_waitcnt #(
        .WAIT_MAX (WAIT_MAX)
    ) u_waitcnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_wait_clr),
        .i_en     (w_wait_en),
        .o_term_c (w_wait_term)
    );

    // State register, sticky trap and retired counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_trap       <= 1'b0;
            r_trap_cause <= CAUSE_NONE;
            r_retired    <= '0;
        end else begin
            r_state <= w_next;
            r_trap  <= (r_state == S_TRAP);
            if (w_cause) begin
                r_trap_cause <= w_cause_code;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next          = r_state;
        w_cause         = 1'b0;
        w_cause_code    = CAUSE_NONE;
        w_retire        = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = ASB_B;
        w_alu_ctrl      = ALU_ADD;
        w_pc_source     = PCS_ALU;

        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = ASB_FOUR;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_wait_term) begin
                    w_next       = S_TRAP;
                    w_cause      = 1'b1;
                    w_cause_code = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                w_alu_src_b = ASB_IMM_SH2;
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_ADDIU:     w_next = S_IMM_EX;
                    OP_BNE:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next       = S_TRAP;
                        w_cause      = 1'b1;
                        w_cause_code = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ASB_IMM;
                w_next      = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_MEM_WB;
                end else if (w_wait_term) begin
                    w_next       = S_TRAP;
                    w_cause      = 1'b1;
                    w_cause_code = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_wait_term) begin
                    w_next       = S_TRAP;
                    w_cause      = 1'b1;
                    w_cause_code = CAUSE_TIMEOUT;
                end
            end
            S_IMM_EX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ASB_IMM;
                w_next      = S_IMM_WB;
            end
            S_IMM_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_ctrl      = ALU_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = PCS_ALUOUT;
                w_retire        = 1'b1;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = PCS_JUMP;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Strobes are held off while reset is asserted
    assign bus.pc_en      = (w_pc_write | (w_pc_write_cond & ~bus.zero)) & ~rst;
    assign bus.mem_read   = w_mem_read  & ~rst;
    assign bus.mem_write  = w_mem_write & ~rst;
    assign bus.ir_write   = w_ir_write  & ~rst;
    assign bus.reg_write  = w_reg_write & ~rst;
    assign bus.i_or_d     = w_i_or_d;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_ctrl   = w_alu_ctrl;
    assign bus.pc_source  = w_pc_source;
    assign bus.state      = r_state;
    assign bus.trap       = r_trap;
    assign bus.trap_cause = r_trap_cause;
    assign bus.retired    = r_retired;

endmodule
